ascii2bcdword_16: RTL
=====================

// Module: ascii2bcdword_16
// PURPOSE
//  Receive-side counterpart of the BCD->ASCII display path: parses a stream of
//  7-bit ASCII characters (e.g. from the UART command RX) into a packed BCD word.
//  Decimal digits arrive MSD first; a terminator closes the frame. The block
//  left-pads short frames with zero digits and rejects malformed frames.
//  Sits between the character source and the channel/threshold setting logic.
// PARAMETERS
//  DIGITS   4       max digits per frame; bcd_word width = 4*DIGITS
//  TERM     7'h0D   frame terminator character (CR)
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          reset, asynchronous, active-low
//  ascii        in   7          input character
//  ascii_valid  in   1          ascii holds a character this cycle
//  ascii_ready  out  1          block can accept a character this cycle
//  bcd_word     out  4*DIGITS   parsed BCD word, digit 0 in [3:0]
//  bcd_ndigits  out  3          number of digits received in frame (1..DIGITS)
//  bcd_valid    out  1          bcd_word/bcd_ndigits valid, held until taken
//  bcd_ready    in   1          consumer takes the word
//  err          out  1          one-cycle pulse: frame rejected
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, accumulator=0, cnt=0, bcd_word=0,
//    bcd_ndigits=0, bcd_valid=0, err=0. Partial frame discarded.
//  - Char accepted on rising clk when ascii_valid && ascii_ready.
//  - ascii_ready = 1 in IDLE, COLLECT, FLUSH; 0 in DONE (decoded from state).
//  - Classes: DIGIT = 7'h30..7'h39 (nibble = ascii[3:0]); TERM; OTHER = rest.
//  - IDLE: DIGIT -> acc={acc[4*DIGITS-5:0],nibble}, cnt=1, -> COLLECT.
//          TERM -> ignored (empty line), stay IDLE, no err.
//          OTHER -> err pulse, -> FLUSH.
//  - COLLECT: DIGIT with cnt<DIGITS -> shift in, cnt+1.
//             DIGIT with cnt==DIGITS -> overflow: err pulse, -> FLUSH.
//             TERM -> bcd_word=acc, bcd_ndigits=cnt, bcd_valid=1, -> DONE.
//             OTHER -> err pulse, -> FLUSH.
//  - FLUSH: discard all chars; TERM -> clear acc/cnt, -> IDLE. No further err.
//  - DONE: outputs held stable; when bcd_ready=1 -> bcd_valid=0, acc=0,
//    cnt=0, -> IDLE next cycle. bcd_word keeps last value after handshake.
//  - Latency: bcd_valid rises the cycle after TERM is accepted; err is high
//    exactly the cycle after the offending char is accepted.
//  - Leading zeros: acc starts at 0, so "42" -> 16'h0042, ndigits=2.
//  - ascii_valid without ascii_ready (DONE): char is not consumed; source holds.
//  - bcd_ready while bcd_valid=0: ignored.
//  - No idle-gap timeout; frame spans any number of cycles.
// STRUCTURE
//  - Shared package/header: ASCII_ZERO 7'h30, ASCII_NINE 7'h39, ASCII_CR 7'h0D,
//    state encoding (IDLE, COLLECT, FLUSH, DONE, 2-bit).
//  - One sub-module: ascii2bcd1_4 (combinational char classifier: is_digit,
//    is_term, nibble), the inverse of the per-digit BCD->ASCII converter.
//  - Top: FSM, shift accumulator, digit counter, output registers.
// TESTING
//  1. "1234"+CR -> bcd_word=16'h1234, ndigits=4, bcd_valid 1 cycle after CR.
//  2. "7"+CR -> bcd_word=16'h0007, ndigits=1; CR alone in IDLE -> no output.
//  3. "12345"+CR -> err pulse after '5', no bcd_valid; then "9"+CR -> 16'h0009.
//  4. "1A2"+CR -> err pulse after 'A', chars flushed, no output; recovers.
//  5. "0560"+CR with bcd_ready=0 for 10 cycles -> ascii_ready=0, word 16'h0560
//     held; bcd_ready=1 -> bcd_valid=0, ascii_ready=1 next cycle.
//  6. "12" then rst=0 mid-cycle -> all outputs 0 immediately; "3"+CR -> 16'h0003.

Source files
------------

// File: rtl/ascii2bcdword_16_pkg.sv
// Shared constants for the ASCII -> packed BCD word parser.
//   ASCII_ZERO/ASCII_NINE : decimal digit character range
//   ASCII_CR              : default frame terminator
//   ST_*                  : 2-bit parser state encoding
//   char_class_t          : classifier result for one character
package ascii2bcdword_16_pkg;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_NINE = 7'h39;
  localparam logic [6:0] ASCII_CR   = 7'h0D;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef struct packed {
    logic       is_digit;
    logic       is_term;
    logic [3:0] nibble;
  } char_class_t;

endpackage

// File: rtl/ascii2bcdword_16_if.sv
// Character-in / BCD-word-out bus of the parser.
//   ascii/ascii_valid/ascii_ready : character stream (ready/valid)
//   bcd_word/bcd_ndigits          : parsed frame, digit 0 in bcd_word[3:0]
//   bcd_valid/bcd_ready           : word handshake, valid held until taken
//   err                           : one-cycle frame-rejected pulse
// slave = the parser, master = character source + word consumer.
interface ascii2bcdword_16_if #(
  parameter int DIGITS = 4
) ();

  logic [6:0]          ascii;
  logic                ascii_valid;
  logic                ascii_ready;
  logic [4*DIGITS-1:0] bcd_word;
  logic [2:0]          bcd_ndigits;
  logic                bcd_valid;
  logic                bcd_ready;
  logic                err;

  modport slave (
    input  ascii, ascii_valid, bcd_ready,
    output ascii_ready, bcd_word, bcd_ndigits, bcd_valid, err
  );

  modport master (
    output ascii, ascii_valid, bcd_ready,
    input  ascii_ready, bcd_word, bcd_ndigits, bcd_valid, err
  );

endinterface

// File: rtl/ascii2bcdword_16_ascii2bcd1_4.sv
// Combinational single-character classifier (inverse of the per-digit
// BCD->ASCII converter).
//   i_ascii : 7-bit character
//   o_cls   : is_digit ('0'..'9'), is_term (== TERM), nibble (= ascii[3:0])
// A character that is neither digit nor terminator is "other".
module ascii2bcd1_4
  import ascii2bcdword_16_pkg::*;
#(
  parameter logic [6:0] TERM = ASCII_CR
) (
  input  logic [6:0]  i_ascii,
  output char_class_t o_cls
);

  logic w_digit;

  assign w_digit         = (i_ascii >= ASCII_ZERO) && (i_ascii <= ASCII_NINE);
  // Digit wins if TERM were ever configured inside the digit range.
  assign o_cls.is_digit  = w_digit;
  assign o_cls.is_term   = !w_digit && (i_ascii == TERM);
  assign o_cls.nibble    = i_ascii[3:0];

endmodule

// File: rtl/ascii2bcdword_16.sv
// Parses an MSD-first stream of ASCII digits closed by TERM into a packed,
// zero-left-padded BCD word. Malformed or over-long frames raise a one-cycle
// err pulse and the rest of the frame (up to TERM) is discarded.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : ascii2bcdword_16_if slave modport (char stream in, word out, err)
module ascii2bcdword_16
  import ascii2bcdword_16_pkg::*;
#(
  parameter int         DIGITS = 4,
  parameter logic [6:0] TERM   = ASCII_CR
) (
  input  logic           clk,
  input  logic           rst,
  ascii2bcdword_16_if.slave bus
);

  localparam int W = 4 * DIGITS;

  logic [1:0]   r_state;
  logic [W-1:0] r_acc;
  logic [2:0]   r_cnt;
  logic [W-1:0] r_word;
  logic [2:0]   r_ndig;
  logic         r_bvalid;
  logic         r_err;

  char_class_t  w_cls;
  logic         w_ready;
  logic         w_take;
  logic [W-1:0] w_shift;

  ascii2bcd1_4 #(.TERM(TERM)) u_cls (
    .i_ascii (bus.ascii),
    .o_cls   (w_cls)
  );

  // Only DONE back-pressures: the source holds its char until the word is taken.
  assign w_ready = (r_state != ST_DONE);
  assign w_take  = bus.ascii_valid && w_ready;
  assign w_shift = {r_acc[W-5:0], w_cls.nibble};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_word   <= '0;
      r_ndig   <= '0;
      r_bvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            if (w_cls.is_digit) begin
              r_acc   <= w_shift;
              r_cnt   <= 3'd1;
              r_state <= ST_COLLECT;
            end else if (!w_cls.is_term) begin
              // Bare TERM is an empty line and is silently dropped.
              r_err   <= 1'b1;
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_COLLECT: begin
          if (w_take) begin
            if (w_cls.is_digit) begin
              if (r_cnt == 3'(DIGITS)) begin
                r_err   <= 1'b1;
                r_state <= ST_FLUSH;
              end else begin
                r_acc <= w_shift;
                r_cnt <= r_cnt + 3'd1;
              end
            end else if (w_cls.is_term) begin
              r_word   <= r_acc;
              r_ndig   <= r_cnt;
              r_bvalid <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (w_take && w_cls.is_term) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          // r_word/r_ndig intentionally keep the last frame after handshake.
          if (bus.bcd_ready) begin
            r_bvalid <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ascii_ready = w_ready;
  assign bus.bcd_word    = r_word;
  assign bus.bcd_ndigits = r_ndig;
  assign bus.bcd_valid   = r_bvalid;
  assign bus.err         = r_err;

endmodule
